// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmitter and receiver.
//   DATA_BITS  : payload bits per frame
//   state_t    : transmitter FSM encoding
//   bit_period : clocks per bit for a given clock (MHz) and line rate (bit/s)
package rs232_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Integer division, truncating; computed in 64 bits so large clock
    // rates do not overflow before the divide.
    function automatic int bit_period(input int mhz, input int baud);
        longint clocks_per_s;
        clocks_per_s = longint'(mhz) * longint'(1_000_000);
        return int'(clocks_per_s / longint'(baud));
    endfunction

endpackage

// File: rtl/rs232_baud_cnt.sv
// Bit-period counter for the RS232 transmitter.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   clr   : hold the count at zero (used while the line is idle)
//   tick  : high in the last clock of a bit period; the count wraps after it
module rs232_baud_cnt #(
    parameter int BIT_PER = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (BIT_PER > 1) ? $clog2(BIT_PER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_PER - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rs232_tx.sv
// Byte-wide RS232 transmitter: 8N1 or 8N2, LSB first, idle-high line, with a
// one-entry holding register so back-to-back frames leave no idle gap.
//   clock         : rising-edge clock
//   reset         : asynchronous active-high reset
//   tx_data       : byte offered by the host
//   tx_vld        : host offers tx_data; taken on any edge where tx_rdy is high
//   tx_rdy        : holding register empty
//   tx_busy       : a frame is in progress
//   RS232_DCE_TXD : registered serial line, 1 = mark
module rs232_tx
    import rs232_pkg::*;
#(
    parameter int baud      = 9600,
    parameter int mhz       = 50,
    parameter int stop_bits = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       tx_busy,
    output logic       RS232_DCE_TXD
);

    localparam int BIT_PER = bit_period(mhz, baud);

    generate
        if (BIT_PER < 2 || (stop_bits != 1 && stop_bits != 2)) begin : g_bad_cfg
            $error("rs232_tx: bit period must be >= 2 clocks and stop_bits 1 or 2");
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_vld_q, hold_vld_d;
    logic [DATA_BITS-1:0]   sr_q, sr_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   txd_q, txd_d;

    logic tick;
    logic last_stop;
    logic load_pt;
    logic accept;
    logic load;

    rs232_baud_cnt #(
        .BIT_PER (BIT_PER)
    ) u_baud_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (state_q == ST_IDLE),
        .tick  (tick)
    );

    // A new frame may start either from idle or seamlessly at the very end
    // of the last stop bit; the held byte has priority over the input port.
    assign last_stop = (state_q == ST_STOP) && tick && (stop_cnt_q == 1'(stop_bits - 1));
    assign load_pt   = (state_q == ST_IDLE) || last_stop;
    assign accept    = tx_vld && !hold_vld_q;
    assign load      = load_pt && (hold_vld_q || accept);

    assign tx_rdy        = ~hold_vld_q;
    assign tx_busy       = (state_q != ST_IDLE);
    assign RS232_DCE_TXD = txd_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (load) state_d = ST_START;
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA:  if (tick && bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
            ST_STOP:  if (last_stop) state_d = load ? ST_START : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The line is driven from next-state values so it is registered yet
    // changes on the same edge as the FSM (start bit begins on the accept edge).
    always_comb begin
        unique case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = sr_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;

        if (load_pt) begin
            if (hold_vld_q) begin
                sr_d       = hold_q;
                hold_vld_d = 1'b0;
            end else if (accept) begin
                sr_d = tx_data;
            end
        end else if (accept) begin
            hold_d     = tx_data;
            hold_vld_d = 1'b1;
        end

        if (state_q == ST_DATA && tick) begin
            sr_d      = {1'b0, sr_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (state_q == ST_STOP && tick) begin
            stop_cnt_d = last_stop ? 1'b0 : stop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// Self-checking bench for rs232_tx at 1 MHz / 100 kbit/s (10 clocks per bit).
// dut1 uses one stop bit, dut2 two stop bits.
module tb_rs232_tx;

    localparam int BP = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data1, tx_data2;
    logic       tx_vld1, tx_vld2;
    logic       rdy1, busy1, txd1;
    logic       rdy2, busy2, txd2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    rs232_tx #(.baud(100000), .mhz(1), .stop_bits(1)) dut1 (
        .clock(clock), .reset(reset), .tx_data(tx_data1), .tx_vld(tx_vld1),
        .tx_rdy(rdy1), .tx_busy(busy1), .RS232_DCE_TXD(txd1)
    );

    rs232_tx #(.baud(100000), .mhz(1), .stop_bits(2)) dut2 (
        .clock(clock), .reset(reset), .tx_data(tx_data2), .tx_vld(tx_vld2),
        .tx_rdy(rdy2), .tx_busy(busy2), .RS232_DCE_TXD(txd2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic line_of(input int d);
        return (d == 0) ? txd1 : txd2;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? busy1 : busy2;
    endfunction

    function automatic logic rdy_of(input int d);
        return (d == 0) ? rdy1 : rdy2;
    endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin
            tx_vld1 = v; tx_data1 = b;
        end else begin
            tx_vld2 = v; tx_data2 = b;
        end
    endtask

    // Reference frame: bit 0 = start (0), bits 1..8 = data LSB first, rest = stop (1).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Expected line k clocks after the first start edge, for frames sent back to back.
    function automatic logic exp_line(input logic [7:0] q[$], input int nstop, input int k);
        int flen;
        flen = (9 + nstop) * BP;
        if (k / flen >= q.size()) return 1'b1;
        return frame_bit(q[k / flen], (k % flen) / BP);
    endfunction

    // Called right after the first accepting edge; checks every clock of the
    // whole burst plus a few idle clocks afterwards.
    task automatic chk_stream(input logic [7:0] q[$], input int nstop, input int d);
        int total;
        total = q.size() * (9 + nstop) * BP;
        for (int k = 0; k < total + 3; k++) begin
            @(negedge clock);
            chk($sformatf("txd%0d[k=%0d]", d + 1, k), line_of(d), exp_line(q, nstop, k));
            chk($sformatf("busy%0d[k=%0d]", d + 1, k), busy_of(d), (k < total));
        end
    endtask

    task automatic single(input int d, input logic [7:0] b, input int nstop);
        logic [7:0] q[$];
        q.push_back(b);
        @(negedge clock); drive(d, 1'b1, b);
        @(posedge clock);
        fork
            chk_stream(q, nstop, d);
            begin
                @(negedge clock);
                chk("single_rdy", rdy_of(d), 1'b1);
                drive(d, 1'b0, 8'h00);
            end
        join
    endtask

    task automatic b2b(input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] q[$];
        q.push_back(b0); q.push_back(b1);
        @(negedge clock); drive(0, 1'b1, b0);
        @(posedge clock);
        fork
            chk_stream(q, 1, 0);
            begin
                @(negedge clock); chk("b2b_rdy_k0", rdy1, 1'b1); tx_data1 = b1;
                @(negedge clock); chk("b2b_rdy_k1", rdy1, 1'b0); tx_vld1 = 1'b0;
                repeat (98) @(negedge clock);
                chk("b2b_rdy_k99", rdy1, 1'b0);
                @(negedge clock); chk("b2b_rdy_k100", rdy1, 1'b1);
            end
        join
    endtask

    task automatic hold_full(input logic [7:0] b0, input logic [7:0] h1, input logic [7:0] h2);
        logic [7:0] q[$];
        q.push_back(b0); q.push_back(h1); q.push_back(h2);
        @(negedge clock); drive(0, 1'b1, b0);
        @(posedge clock);
        fork
            chk_stream(q, 1, 0);
            begin
                @(negedge clock); tx_vld1 = 1'b0;
                repeat (30) @(negedge clock);
                tx_vld1 = 1'b1; tx_data1 = h1;
                @(negedge clock); chk("hold_rdy_k31", rdy1, 1'b0); tx_data1 = h2;
                repeat (68) @(negedge clock); chk("hold_rdy_k99", rdy1, 1'b0);
                @(negedge clock); chk("hold_rdy_k100", rdy1, 1'b1);
                @(negedge clock); chk("hold_rdy_k101", rdy1, 1'b0); tx_vld1 = 1'b0;
                repeat (98) @(negedge clock); chk("hold_rdy_k199", rdy1, 1'b0);
                @(negedge clock); chk("hold_rdy_k200", rdy1, 1'b1);
            end
        join
    endtask

    // Behavioural receiver: detect start, sample each bit at its centre.
    task automatic rx_byte(input int d, output logic [7:0] b, output logic ok);
        int   w;
        logic found, st, sp;
        b = 8'h00; ok = 1'b0; found = 1'b0; w = 0;
        while (!found && w < 100) begin
            @(negedge clock);
            w++;
            if (line_of(d) === 1'b0) found = 1'b1;
        end
        if (!found) return;
        repeat (BP / 2) @(negedge clock);
        st = line_of(d);
        for (int i = 0; i < 8; i++) begin
            repeat (BP) @(negedge clock);
            b[i] = line_of(d);
        end
        repeat (BP) @(negedge clock);
        sp = line_of(d);
        ok = (st === 1'b0) && (sp === 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lb[$];
        logic [7:0] rb;
        logic       rok;

        reset = 1'b1;
        tx_vld1 = 1'b0; tx_data1 = 8'h00;
        tx_vld2 = 1'b0; tx_data2 = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_txd1", txd1, 1'b1);
        chk("rst_rdy1", rdy1, 1'b1);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_txd2", txd2, 1'b1);
        chk("rst_rdy2", rdy2, 1'b1);
        chk("rst_busy2", busy2, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        single(0, 8'hA5, 1);
        repeat (2) single(0, 8'($urandom), 1);

        b2b(8'h00, 8'hFF);
        b2b(8'($urandom), 8'($urandom));

        hold_full(8'($urandom), 8'h11, 8'h22);

        single(1, 8'h3C, 2);
        single(1, 8'($urandom), 2);

        // Reset in the middle of bit 3 of 0x5A with a second byte held.
        @(negedge clock); drive(0, 1'b1, 8'h5A);
        @(posedge clock);
        @(negedge clock); tx_vld1 = 1'b0;
        repeat (4) @(negedge clock);
        tx_vld1 = 1'b1; tx_data1 = 8'h77;
        @(negedge clock); tx_vld1 = 1'b0;
        chk("midrst_held", rdy1, 1'b0);
        repeat (39) @(negedge clock);
        chk("midrst_bit3", txd1, frame_bit(8'h5A, 4));
        #2 reset = 1'b1;
        #1;
        chk("midrst_txd", txd1, 1'b1);
        chk("midrst_rdy", rdy1, 1'b1);
        chk("midrst_busy", busy1, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            chk("postrst_txd", txd1, 1'b1);
            chk("postrst_busy", busy1, 1'b0);
        end
        single(0, 8'h81, 1);

        // Loopback through the behavioural receiver (mark = 1, LSB first).
        lb.push_back(8'h00); lb.push_back(8'h55); lb.push_back(8'hFF);
        lb.push_back(8'($urandom)); lb.push_back(8'($urandom));
        foreach (lb[i]) begin
            fork
                rx_byte(0, rb, rok);
                begin
                    @(negedge clock); drive(0, 1'b1, lb[i]);
                    @(posedge clock);
                    @(negedge clock); tx_vld1 = 1'b0;
                end
            join
            chk($sformatf("rx_byte[%0d]", i), rb, lb[i]);
            chk($sformatf("rx_frame[%0d]", i), rok, 1'b1);
            repeat (10) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
